gate_bist_ctrl: RTL
===================

# gate_bist_ctrl

Built-in self-test driver and response reader for the 18-input / 10-output combinational gate models in the gate library.
- Generates pseudo-random stimulus on the model's inputs N1..N18 and compacts the model's outputs into a 10-bit signature.
- Reports done/pass against an expected signature.
- Sits between the lab microcomputer's test register file and any GateModel instance; it is the active end of the model's port interface.

## Interface
- PATTERN_COUNT, 256: patterns applied per run; range 1..65535.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a run; honoured in IDLE and DONE only.
- abort  in  1  return to IDLE from any state; has priority over start.
- seed  in  18  LFSR seed, sampled on accepted start.
- expected_sig  in  10  golden signature, compared in DONE.
- resp  in  10  model outputs, bit order: N101,N108,N109,N110,N112,N114,N115,N116,N117,N118 (resp[0]=N101).
- stim  out  18  model inputs, stim[0]=N1 … stim[17]=N18; registered.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done && (signature == expected_sig).
- signature  out  10  MISR contents.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, stim=0, signature=0, cnt=0, busy=done=pass=0.
- IDLE/DONE + start (abort low) → RUN:
  - stim ← seed, or 18'h00001 if seed==0.
  - signature ← 0, cnt ← 0.
- RUN, every cycle:
  - signature ← MISR(signature, resp).
  - stim ← LFSR(stim).
  - cnt ← cnt+1.
  - When cnt==PATTERN_COUNT-1 → DONE, stim ← 0, cnt frozen.
- DONE: signature held; done=1 until start (restart) or abort.
- abort in any state → IDLE, stim=0, signature=0. Abort wins over simultaneous start.
- start in RUN is ignored.
- LFSR: 18-bit Fibonacci, polynomial x^18+x^11+1, shift left, new bit0 = q[17]^q[10]. Maximal length; all-zero is never entered.
- MISR: 10-bit, polynomial x^10+x^3+1, fb = s[9]:
  - s'[0] = fb^r[0]
  - s'[3] = s[2]^fb^r[3]
  - s'[i] = s[i-1]^r[i] for all other i
- cnt is 16 bits; no wrap can occur because PATTERN_COUNT ≤ 65535.

## Timing
- The model is purely combinational, so resp for the stim visible in cycle k is absorbed at the rising edge that ends cycle k. Zero-latency compaction; no pipeline stage.
- start accepted at edge e0 → busy=1 from e0. Exactly PATTERN_COUNT patterns are absorbed. done=1 from edge e0+PATTERN_COUNT.
- pass is combinational from registered state; valid in the same cycle done rises.
- expected_sig may change while in DONE; pass follows it.
- Reset asserted mid-run: all outputs return to reset values immediately (async). First start after deassertion begins a clean run.

## Structure
- Package gate_bist_pkg:
  - state enum (IDLE, RUN, DONE)
  - LFSR_TAP_HI=17, LFSR_TAP_LO=10, MISR_TAP=3
  - N_STIM=18, N_RESP=10
- Sub-module gate_misr: 10-bit MISR with ports clk, rst_n, clr, en, resp, signature.
- LFSR, counter and FSM stay in the top module.

## Test plan
- Seed 18'h00001, resp=0, PATTERN_COUNT=12: stim sequence 0x00001,0x00002,…,0x00400 then 0x00801 → signature 0, done after 12 cycles, pass with expected_sig=0.
- PATTERN_COUNT=2, resp held 10'h001 → signature 10'h003, pass only with expected_sig=10'h003.
- Seed 0 → first stim 18'h00001. Run a connected GateModel twice with the same seed → identical signatures.
- Start pulse while busy → ignored; run length unchanged. Abort in cycle 5 → IDLE next edge, stim=0, signature=0, done=0.
- rst_n low mid-run → outputs zero asynchronously. Restart → signature matches an uninterrupted run.
- Start and abort asserted together in DONE → IDLE; done=0, busy=0.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared states, widths, taps and the LFSR step for the gate BIST controller
package gate_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 10;
  localparam int MISR_TAP = 3;
  localparam int N_STIM = 18;
  localparam int N_RESP = 10;
  function automatic logic [N_STIM-1:0] lfsr_next(input logic [N_STIM-1:0] q);
    return {q[N_STIM-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction
endpackage

// File: rtl/gate_misr.sv
// gate_misr: 10-bit MISR (x^10+x^3+1) compacting model responses
// ports: clk, rst_n (async active-low), clr (zero signature, wins over en),
//        en (absorb resp this edge), resp (model outputs), signature (MISR contents)
module gate_misr
  import gate_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [N_RESP-1:0] resp,
  output logic [N_RESP-1:0] signature
);
  localparam logic [N_RESP-1:0] POLY = N_RESP'(1) | (N_RESP'(1) << MISR_TAP);
  logic [N_RESP-1:0] sig_d, sig_q;
  always_comb
    sig_d = clr ? '0 :
            en  ? ({sig_q[N_RESP-2:0], 1'b0} ^ resp ^ (sig_q[N_RESP-1] ? POLY : '0)) :
                  sig_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  assign signature = sig_q;
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR stimulus driver and MISR response reader for 18-in/10-out gate models
// ports: clk, rst_n (async active-low), start, abort, seed, expected_sig, resp (model outputs)
//        -> stim (model inputs), busy, done, pass, signature
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int PATTERN_COUNT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N_STIM-1:0] seed,
  input  logic [N_RESP-1:0] expected_sig,
  input  logic [N_RESP-1:0] resp,
  output logic [N_STIM-1:0] stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_RESP-1:0] signature
);
  localparam logic [15:0] LAST = 16'(PATTERN_COUNT - 1);
  state_t            state_q, state_d;
  logic [N_STIM-1:0] stim_q, stim_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic              accept, clr, last;
  assign accept = start && !abort && state_q != RUN;
  assign clr    = abort || accept;
  assign last   = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      stim_d  = '0;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = RUN;
      // all-zero is the LFSR lock-up state, so a zero seed is replaced
      stim_d  = (seed == '0) ? N_STIM'(1) : seed;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      state_d = last ? DONE : RUN;
      stim_d  = last ? '0 : lfsr_next(stim_q);
      cnt_d   = last ? cnt_q : cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      busy_q  <= state_d == RUN;
      done_q  <= state_d == DONE;
    end
  // resp belongs to the stim currently on the bus, so it is absorbed on every RUN edge
  gate_misr u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (state_q == RUN),
    .resp      (resp),
    .signature (signature)
  );
  assign stim = stim_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = done_q && (signature == expected_sig);
endmodule
